// File: rtl/zx_mem_pkg.sv
// Types shared by the SDRAM port arbiter and its testbench: address width,
// address type and arbiter state encoding.
`timescale 1ns/1ps
package zx_mem_pkg;

  localparam int AW = 25;

  typedef logic [AW-1:0] sram_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    IOCTL,
    CPU,
    TAPE_RD,
    TAPE_HIT
  } arb_state_t;

endpackage

// File: rtl/refresh_edge_det.sv
// Two-flop nRFSH sampler producing one-cycle refresh fall/rise pulses.
`timescale 1ns/1ps
module refresh_edge_det (
  input  logic clk_sys,
  input  logic nRESET,
  input  logic nRFSH,
  output logic rfsh_fall,
  output logic rfsh_rise
);

  logic rfsh_cur;
  logic rfsh_prev;

  // Both samples reset high so leaving reset never looks like a refresh edge
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      rfsh_cur  <= 1'b1;
      rfsh_prev <= 1'b1;
    end else begin
      rfsh_cur  <= nRFSH;
      rfsh_prev <= rfsh_cur;
    end
  end

  assign rfsh_fall = rfsh_prev & ~rfsh_cur;
  assign rfsh_rise = ~rfsh_prev & rfsh_cur;

endmodule

// File: rtl/sram_port_arbiter.sv
// Registered scheduler for the byte-wide SDRAM port: download, CPU and
// refresh-window tape fetches with a one-entry tape address cache.
`timescale 1ns/1ps
module sram_port_arbiter #(
  parameter int AW       = zx_mem_pkg::AW,
  parameter int READ_LAT = 6,
  parameter int CNT_W    = 3
) (
  input  logic          clk_sys,
  input  logic          nRESET,
  input  logic          ioctl_req,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          cpu_rd,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          nRFSH,
  input  logic          tape_req,
  input  logic [AW-1:0] tape_addr,
  output logic [7:0]    tape_data,
  output logic          tape_ack,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_din,
  output logic          sram_we,
  output logic          sram_rd,
  input  logic [7:0]    sram_dout,
  output logic          busy_tape
);

  import zx_mem_pkg::arb_state_t;
  import zx_mem_pkg::IDLE;
  import zx_mem_pkg::IOCTL;
  import zx_mem_pkg::CPU;
  import zx_mem_pkg::TAPE_RD;
  import zx_mem_pkg::TAPE_HIT;

  arb_state_t       state;
  arb_state_t       next_state;
  logic             rfsh_fall;
  logic             rfsh_rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [AW-1:0]    cache_addr;
  logic [AW-1:0]    cache_addr_d;
  logic             cache_valid;
  logic             cache_valid_d;
  logic [AW-1:0]    addr_d;
  logic [7:0]       din_d;
  logic [7:0]       data_d;
  logic             we_d;
  logic             rd_d;
  logic             ack_d;
  logic             busy_d;
  logic             cpu_req;
  logic             cache_hit;
  logic             tape_abort;
  logic             fetch_done;

  refresh_edge_det u_rfsh (
    .clk_sys   (clk_sys),
    .nRESET    (nRESET),
    .nRFSH     (nRFSH),
    .rfsh_fall (rfsh_fall),
    .rfsh_rise (rfsh_rise)
  );

  assign cpu_req    = cpu_rd | cpu_we;
  assign cache_hit  = cache_valid && (tape_addr == cache_addr);
  assign tape_abort = rfsh_rise | ioctl_req;
  assign fetch_done = (cnt == CNT_W'(1));

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (ioctl_req)                 next_state = IOCTL;
        else if (cpu_req)              next_state = CPU;
        else if (tape_req && rfsh_fall) next_state = cache_hit ? TAPE_HIT : TAPE_RD;
      end
      IOCTL:    if (!ioctl_req) next_state = IDLE;
      CPU:      if (!cpu_req)   next_state = IDLE;
      TAPE_RD:  if (tape_abort || fetch_done) next_state = IDLE;
      TAPE_HIT: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Next values of every registered output plus the fetch counter and cache
  always_comb begin
    addr_d        = sram_addr;
    din_d         = sram_din;
    we_d          = 1'b0;
    rd_d          = 1'b0;
    ack_d         = 1'b0;
    data_d        = tape_data;
    busy_d        = 1'b0;
    cnt_d         = cnt;
    cache_addr_d  = cache_addr;
    cache_valid_d = cache_valid;
    if ((state == IOCTL) || (state == IDLE && next_state == IOCTL)) begin
      addr_d = ioctl_addr;
      din_d  = ioctl_data;
      we_d   = ioctl_wr;
      if (ioctl_wr && ioctl_addr == cache_addr) cache_valid_d = 1'b0;
    end else if ((state == CPU) || (state == IDLE && next_state == CPU)) begin
      addr_d = cpu_addr;
      din_d  = cpu_din;
      we_d   = cpu_we;
      rd_d   = cpu_rd & ~cpu_we;
      if (cpu_we && cpu_addr == cache_addr) cache_valid_d = 1'b0;
    end else if (state == IDLE && next_state == TAPE_HIT) begin
      ack_d = 1'b1;
    end else if (state == IDLE && next_state == TAPE_RD) begin
      addr_d = tape_addr;
      rd_d   = 1'b1;
      busy_d = 1'b1;
      cnt_d  = CNT_W'(READ_LAT);
    end else if (state == TAPE_RD && !tape_abort) begin
      // sram_addr still holds the address latched at fetch start
      if (fetch_done) begin
        data_d        = sram_dout;
        ack_d         = 1'b1;
        cache_addr_d  = sram_addr;
        cache_valid_d = 1'b1;
      end else begin
        rd_d   = 1'b1;
        busy_d = 1'b1;
        cnt_d  = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      sram_addr   <= '0;
      sram_din    <= '0;
      sram_we     <= 1'b0;
      sram_rd     <= 1'b0;
      tape_data   <= '0;
      tape_ack    <= 1'b0;
      busy_tape   <= 1'b0;
      cnt         <= '0;
      cache_addr  <= '0;
      cache_valid <= 1'b0;
    end else begin
      sram_addr   <= addr_d;
      sram_din    <= din_d;
      sram_we     <= we_d;
      sram_rd     <= rd_d;
      tape_data   <= data_d;
      tape_ack    <= ack_d;
      busy_tape   <= busy_d;
      cnt         <= cnt_d;
      cache_addr  <= cache_addr_d;
      cache_valid <= cache_valid_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: per-cycle vector table for download/CPU
// traffic, scripted refresh-window tape sequences, write/ack scoreboards.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  import zx_mem_pkg::*;

  localparam int READ_LAT = 6;

  logic       clk_sys = 1'b0;
  logic       nRESET;
  logic       ioctl_req, ioctl_wr;
  sram_addr_t ioctl_addr;
  logic [7:0] ioctl_data;
  logic       cpu_rd, cpu_we;
  sram_addr_t cpu_addr;
  logic [7:0] cpu_din;
  logic       nRFSH, tape_req;
  sram_addr_t tape_addr;
  logic [7:0] tape_data;
  logic       tape_ack;
  sram_addr_t sram_addr;
  logic [7:0] sram_din;
  logic       sram_we, sram_rd;
  logic [7:0] sram_dout;
  logic       busy_tape;

  typedef struct packed {
    sram_addr_t addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       ireq, iwr;
    sram_addr_t iaddr;
    logic [7:0] idata;
    logic       crd, cwe;
    sram_addr_t caddr;
    logic [7:0] cdin;
    logic       ewe, erd;
    sram_addr_t eaddr;
    logic [7:0] edin;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  int         rd_age = 0;
  int         n;
  logic [7:0] mem_byte;
  wr_t        we_q[$];
  logic [7:0] ack_q[$];
  vec_t       vt[$];
  wr_t        mon_w;
  logic [7:0] mon_b;

  always #18 clk_sys = ~clk_sys;

  sram_port_arbiter #(.AW(AW), .READ_LAT(READ_LAT), .CNT_W(3)) dut (
    .clk_sys    (clk_sys),
    .nRESET     (nRESET),
    .ioctl_req  (ioctl_req),
    .ioctl_wr   (ioctl_wr),
    .ioctl_addr (ioctl_addr),
    .ioctl_data (ioctl_data),
    .cpu_rd     (cpu_rd),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .nRFSH      (nRFSH),
    .tape_req   (tape_req),
    .tape_addr  (tape_addr),
    .tape_data  (tape_data),
    .tape_ack   (tape_ack),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_we    (sram_we),
    .sram_rd    (sram_rd),
    .sram_dout  (sram_dout),
    .busy_tape  (busy_tape)
  );

  // SDRAM read model: data is valid only READ_LAT cycles after rd rises
  always @(posedge clk_sys) rd_age <= sram_rd ? rd_age + 1 : 0;
  assign sram_dout = (sram_rd && rd_age == READ_LAT - 1) ? mem_byte : 8'hEE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  always @(negedge clk_sys) begin
    if (nRESET) begin
      if (sram_we || sram_rd) check("we_rd_exclusive", {sram_we, sram_rd}, {sram_we, 1'b0} | {1'b0, ~sram_we});
      if (sram_we) begin
        if (we_q.size() == 0) check("unexpected_write", {sram_addr, sram_din}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          mon_w = we_q.pop_front();
          check("write_addr", sram_addr, mon_w.addr);
          check("write_data", sram_din, mon_w.data);
        end
      end
      if (tape_ack) begin
        if (ack_q.size() == 0) check("unexpected_ack", tape_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          mon_b = ack_q.pop_front();
          check("ack_data", tape_data, mon_b);
        end
      end
    end
  end

  function automatic vec_t mk(input logic ireq, input logic iwr, input sram_addr_t iaddr,
                              input logic [7:0] idata, input logic crd, input logic cwe,
                              input sram_addr_t caddr, input logic [7:0] cdin, input logic ewe,
                              input logic erd, input sram_addr_t eaddr, input logic [7:0] edin);
    vec_t v;
    v = '{ireq, iwr, iaddr, idata, crd, cwe, caddr, cdin, ewe, erd, eaddr, edin};
    return v;
  endfunction

  task automatic wait_rd(output int cnt);
    cnt = 0;
    while (!sram_rd && cnt < 12) begin tick(); cnt++; end
  endtask

  task automatic wait_ack(output int cnt);
    cnt = 0;
    while (!tape_ack && cnt < 20) begin tick(); cnt++; end
  endtask

  // Cache-miss fetch in one refresh window; tape_addr wobbles mid-fetch
  task automatic tape_fetch(input sram_addr_t a, input logic [7:0] b, input string tag);
    int c;
    mem_byte  = b;
    tape_addr = a;
    tape_req  = 1'b1;
    ack_q.push_back(b);
    nRFSH = 1'b0;
    wait_rd(c);
    check({tag, "_rd_delay"}, c, 2);
    check({tag, "_rd_rise"}, sram_rd, 1'b1);
    check({tag, "_rd_addr"}, sram_addr, a);
    check({tag, "_busy"}, busy_tape, 1'b1);
    tape_addr = a + 25'd7;
    wait_ack(c);
    check({tag, "_ack_latency"}, c, READ_LAT);
    check({tag, "_rd_drop"}, sram_rd, 1'b0);
    tick();
    check({tag, "_ack_pulse"}, tape_ack, 1'b0);
    nRFSH    = 1'b1;
    tape_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic tape_hit(input sram_addr_t a, input logic [7:0] b, input string tag);
    mem_byte  = 8'h11;
    tape_addr = a;
    tape_req  = 1'b1;
    ack_q.push_back(b);
    nRFSH = 1'b0;
    tick();
    check({tag, "_early"}, tape_ack, 1'b0);
    tick();
    check({tag, "_ack"}, tape_ack, 1'b1);
    check({tag, "_no_rd"}, sram_rd, 1'b0);
    tick();
    check({tag, "_pulse"}, {tape_ack, sram_rd}, 2'b00);
    nRFSH    = 1'b1;
    tape_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nRESET = 1'b0;
    ioctl_req = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    nRFSH = 1'b1; tape_req = 1'b0; tape_addr = '0; mem_byte = '0;
    tick(); tick(); tick();
    check("reset_outputs", {sram_addr, sram_din, sram_we, sram_rd, tape_data, tape_ack, busy_tape}, 0);
    nRESET = 1'b1;
    tick();

    // ireq iwr iaddr idata | crd cwe caddr cdin || we rd addr din
    vt.push_back(mk(1, 0, 'h100, 8'hA5, 0, 0, 'h0, 8'h00, 0, 0, 'h100, 8'hA5));
    vt.push_back(mk(1, 1, 'h100, 8'hA5, 0, 0, 'h0, 8'h00, 1, 0, 'h100, 8'hA5));
    vt.push_back(mk(1, 0, 'h101, 8'hA6, 0, 0, 'h0, 8'h00, 0, 0, 'h101, 8'hA6));
    vt.push_back(mk(1, 1, 'h101, 8'hA6, 0, 0, 'h0, 8'h00, 1, 0, 'h101, 8'hA6));
    vt.push_back(mk(1, 1, 'h102, 8'hA7, 0, 0, 'h0, 8'h00, 1, 0, 'h102, 8'hA7));
    vt.push_back(mk(0, 1, 'h103, 8'hA8, 0, 0, 'h0, 8'h00, 1, 0, 'h103, 8'hA8));
    vt.push_back(mk(0, 0, 'h103, 8'hA8, 0, 0, 'h0, 8'h00, 0, 0, 'h103, 8'hA8));
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 0, 'h0, 8'h00, 1, 0, 'h0014000, 8'h00, 0, 1, 'h0014000, 8'h00));
    vt.push_back(mk(0, 0, 'h0, 8'h00, 0, 1, 'h0014000, 8'h3C, 1, 0, 'h0014000, 8'h3C));
    vt.push_back(mk(0, 0, 'h0, 8'h00, 0, 1, 'h0014000, 8'h3C, 1, 0, 'h0014000, 8'h3C));
    vt.push_back(mk(0, 0, 'h0, 8'h00, 0, 0, 'h0014000, 8'h3C, 0, 0, 'h0014000, 8'h3C));
    vt.push_back(mk(0, 0, 'h0, 8'h00, 0, 0, 'h0014000, 8'h3C, 0, 0, 'h0014000, 8'h3C));
    vt.push_back(mk(0, 0, 'h0, 8'h00, 1, 1, 'h0014001, 8'h55, 1, 0, 'h0014001, 8'h55));
    vt.push_back(mk(0, 0, 'h0, 8'h00, 0, 0, 'h0014001, 8'h55, 0, 0, 'h0014001, 8'h55));
    vt.push_back(mk(1, 0, 'h200, 8'h00, 1, 0, 'h0014002, 8'h00, 0, 0, 'h200, 8'h00));
    vt.push_back(mk(0, 0, 'h200, 8'h00, 1, 0, 'h0014002, 8'h00, 0, 0, 'h200, 8'h00));
    vt.push_back(mk(0, 0, 'h200, 8'h00, 1, 0, 'h0014002, 8'h00, 0, 1, 'h0014002, 8'h00));
    vt.push_back(mk(0, 0, 'h200, 8'h00, 0, 0, 'h0014002, 8'h00, 0, 0, 'h0014002, 8'h00));

    foreach (vt[i]) begin
      ioctl_req = vt[i].ireq; ioctl_wr = vt[i].iwr;
      ioctl_addr = vt[i].iaddr; ioctl_data = vt[i].idata;
      cpu_rd = vt[i].crd; cpu_we = vt[i].cwe;
      cpu_addr = vt[i].caddr; cpu_din = vt[i].cdin;
      if (vt[i].ewe) we_q.push_back('{vt[i].eaddr, vt[i].edin});
      tick();
      check($sformatf("vec%0d_we", i), sram_we, vt[i].ewe);
      check($sformatf("vec%0d_rd", i), sram_rd, vt[i].erd);
      check($sformatf("vec%0d_addr", i), sram_addr, vt[i].eaddr);
      check($sformatf("vec%0d_din", i), sram_din, vt[i].edin);
    end
    ioctl_req = 1'b0; ioctl_wr = 1'b0; cpu_rd = 1'b0; cpu_we = 1'b0;
    tick();

    tape_fetch('h0400000, 8'h7E, "miss");
    tape_hit('h0400000, 8'h7E, "hit");

    // Refresh ends three cycles into the fetch
    mem_byte = 8'h22; tape_addr = 'h0400001; tape_req = 1'b1; nRFSH = 1'b0;
    wait_rd(n);
    check("abort_rd_rise", sram_rd, 1'b1);
    tick(); tick();
    nRFSH = 1'b1;
    tick();
    check("abort_rd_hold", sram_rd, 1'b1);
    tick();
    check("abort_rd_drop", {sram_rd, busy_tape, tape_ack}, 3'b000);
    repeat (8) tick();
    tape_fetch('h0400001, 8'h22, "retry");
    tape_hit('h0400001, 8'h22, "retry_hit");

    // Download write to the cached tape address invalidates the entry
    ioctl_req = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 'h0400001; ioctl_data = 8'h99;
    we_q.push_back('{sram_addr_t'('h0400001), 8'h99});
    tick();
    check("inv_we", sram_we, 1'b1);
    ioctl_wr = 1'b0; ioctl_req = 1'b0;
    tick(); tick();
    tape_fetch('h0400001, 8'h33, "inv");

    // Download request mid-fetch aborts it and takes the port next cycle
    mem_byte = 8'h55; tape_addr = 'h0400005; tape_req = 1'b1; nRFSH = 1'b0;
    wait_rd(n);
    check("ioabort_rd_rise", sram_rd, 1'b1);
    tick();
    ioctl_req = 1'b1;
    tick();
    check("ioabort_rd_drop", {sram_rd, busy_tape, tape_ack}, 3'b000);
    ioctl_wr = 1'b1; ioctl_addr = 'h0000123; ioctl_data = 8'h5A;
    we_q.push_back('{sram_addr_t'('h0000123), 8'h5A});
    tick();
    check("ioabort_we", sram_we, 1'b1);
    ioctl_wr = 1'b0; ioctl_req = 1'b0; nRFSH = 1'b1; tape_req = 1'b0;
    tick(); tick(); tick();

    // Reset with the fetch counter at 3
    mem_byte = 8'h66; tape_addr = 'h0400010; tape_req = 1'b1; nRFSH = 1'b0;
    wait_rd(n);
    check("rst_rd_rise", sram_rd, 1'b1);
    tick(); tick(); tick();
    nRESET = 1'b0;
    #1;
    check("rst_mid_fetch", {sram_addr, sram_din, sram_we, sram_rd, tape_data, tape_ack, busy_tape}, 0);
    tape_req = 1'b0; nRFSH = 1'b1;
    tick(); tick();
    nRESET = 1'b1;
    tick(); tick();
    check("post_rst_idle", {sram_rd, tape_ack, busy_tape}, 3'b000);
    tape_fetch('h0400001, 8'h77, "post_rst");

    tick(); tick();
    check("write_queue_drained", we_q.size(), 0);
    check("ack_queue_drained", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sequences the single byte-wide SDRAM controller port (sram) among three requesters: the data_io download stream (ioctl), CPU memory cycles, and the tape player's byte fetches.
- Replaces the ad-hoc combinational mux and the refresh-slot tape fetch logic in the top level with one registered scheduler.
- Tape fetches use Z80 refresh windows (nRFSH low). Each fetch is guarded by a one-entry address cache and has a fixed-latency read completion.

Parameters:
AW, 25, SDRAM byte address width
READ_LAT, 6, clk_sys cycles from sram rd assertion to valid sram dout
CNT_W, 3, width of the latency counter; must satisfy 2^CNT_W > READ_LAT

Ports:
clk_sys  in  1  system clock, 28 MHz
nRESET  in  1  asynchronous active-low reset
ioctl_req  in  1  download owns the bus ((!nRESET || !nBUSACK) && !nBUSRQ, synchronised by caller)
ioctl_wr  in  1  download write strobe, one clk_sys cycle
ioctl_addr  in  AW  download address
ioctl_data  in  8  download byte
cpu_rd  in  1  CPU memory read level, held for the whole cycle
cpu_we  in  1  CPU memory write level, held for the whole cycle
cpu_addr  in  AW  CPU mapped address
cpu_din  in  8  CPU write byte
nRFSH  in  1  Z80 refresh strobe, active-low
tape_req  in  1  tape wants byte at tape_addr (level)
tape_addr  in  AW  tape byte address
tape_data  out  8  last fetched tape byte
tape_ack  out  1  one-cycle pulse: tape_data valid for tape_addr
sram_addr  out  AW  to sram.addr
sram_din  out  8  to sram.din
sram_we  out  1  to sram.we
sram_rd  out  1  to sram.rd
sram_dout  in  8  from sram.dout
busy_tape  out  1  tape fetch in flight (debug/LED)

Behaviour:
- All outputs are registered. On reset, every output is 0, the state is IDLE, cache_valid is 0 and cache_addr is 0. Reset is honoured in any state; an in-flight fetch is dropped and no ack is issued.
- States: IDLE, IOCTL, CPU, TAPE_RD, TAPE_HIT.
- Priority is evaluated in IDLE each cycle: ioctl_req, then (cpu_rd|cpu_we), then tape.
- IDLE→IOCTL on ioctl_req.
  - In IOCTL: sram_addr/din/we follow ioctl_* with 1 cycle of delay, and sram_rd is 0.
  - Exit to IDLE on the cycle after ioctl_req falls. A pending ioctl_wr on that edge is still forwarded.
  - Any ioctl write that overlaps cache_addr clears cache_valid.
- IDLE→CPU on cpu_rd|cpu_we when ioctl_req is 0.
  - In CPU: sram_addr=cpu_addr, sram_din=cpu_din, sram_rd=cpu_rd, sram_we=cpu_we, registered with 1 cycle of delay.
  - Return to IDLE when both levels are 0. This produces zero strobes in that cycle.
  - A CPU write to cache_addr clears cache_valid.
  - cpu_rd and cpu_we both high is illegal; write wins and rd is forced to 0.
- Tape entry from IDLE requires a falling edge of nRFSH (previous sample 1, current 0) with tape_req=1, cpu idle and ioctl_req=0.
  - If cache_valid && tape_addr==cache_addr: go to TAPE_HIT. Pulse tape_ack for 1 cycle with no SDRAM access, then return to IDLE.
  - Otherwise go to TAPE_RD: load cnt=READ_LAT, drive sram_addr=tape_addr and sram_rd=1 (held), sram_we=0, busy_tape=1.
- In TAPE_RD, cnt decrements each cycle. When cnt==1:
  - latch sram_dout into tape_data;
  - cache_addr<=tape_addr, cache_valid<=1;
  - pulse tape_ack;
  - drop sram_rd next cycle;
  - go to IDLE.
- nRFSH rising while in TAPE_RD aborts the fetch:
  - sram_rd goes to 0 next cycle; no ack; cache is unchanged; go to IDLE.
  - The fetch retries on the next refresh edge.
- ioctl_req rising in TAPE_RD also aborts, in the same way as a refresh rise. ioctl then wins on the following cycle.
- CPU requests cannot coincide with a refresh window by Z80 timing. If one appears in TAPE_RD it is held off until TAPE_RD exits; no CPU strobes are forwarded meanwhile.
- tape_addr changing mid-fetch is ignored. The latched address is used, and completion caches the address that was actually fetched.
- Only one of sram_we/sram_rd is ever high; sram_we is never high outside IOCTL/CPU.

Decomposition:
- Shared package zx_mem_pkg holds: typedef arb_state_t (5-state enum), localparam AW, and typedef sram_addr_t logic[AW-1:0].
- One sub-module, refresh_edge_det: a 2-flop nRFSH sampler producing the rfsh_fall and rfsh_rise pulses.
- The counter and cache stay inline.

Test Plan:
- Reset mid-TAPE_RD (cnt=3) → all outputs 0 next cycle, no tape_ack, cache_valid=0.
- ioctl_req=1 with 4 writes to 0x000100..0x000103, data A5..A8 → sram_we pulses 1 cycle after each write, matching addr/data; sram_rd stays 0.
- cpu_rd at 0x0014000 for 8 cycles → sram_rd high cycles 2-9, addr 0x0014000; cpu_we with data 0x3C → sram_we and din 0x3C; exit gives zero strobes.
- tape_req addr 0x0400000, nRFSH fall, sram_dout=0x7E → tape_ack exactly READ_LAT cycles after sram_rd rises, tape_data=0x7E; second fall with the same addr → ack 1 cycle later, no sram_rd.
- nRFSH rises 3 cycles into fetch → sram_rd drops, no ack; next fall → full fetch completes.
- ioctl write to cached tape address, then same tape request → cache miss, sram_rd issued.
